// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: shared router constants and arbiter state encoding
package output_port_arbiter_pkg;
  localparam int NUM_PORTS = 5;
  localparam logic [2:0] LOCAL = 3'd0;
  localparam logic [2:0] N = 3'd1;
  localparam logic [2:0] E = 3'd2;
  localparam logic [2:0] S = 3'd3;
  localparam logic [2:0] W = 3'd4;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
  function automatic logic [2:0] next_port(input logic [2:0] p);
    return p >= 3'd4 ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/output_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: first requester at or after ptr, scanning upward modulo 5
module rr_priority_pick
  import output_port_arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] pick,
  output logic [2:0] index
);
  logic [2:0] p;
  logic [2:0] c;
  // scan from the far end back toward ptr so the nearest requester wins last
  always_comb begin
    p = ptr > 3'd4 ? 3'd0 : ptr;
    index = '0;
    c = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      c = 3'((int'(p) + k) % NUM_PORTS);
      if (req[c]) index = c;
    end
    pick = |req ? 5'd1 << index : 5'd0;
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter holding one output port per packet
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int PORT_ID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] flit_valid,
  input  logic [NUM_IN-1:0] flit_tail,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] gnt,
  output logic              gnt_valid,
  output logic [2:0]        owner,
  output logic              xfer,
  output logic [CNT_W-1:0]  pkt_count
);
  if (NUM_IN != NUM_PORTS || PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_cfg
    $error("output_port_arbiter: NUM_IN must be 5 and PORT_ID in 0..4");
  end
  arb_state_t state, state_nxt;
  logic [4:0] gnt_nxt, pick;
  logic [2:0] owner_nxt, rr_ptr, ptr_nxt, pick_idx;
  logic [CNT_W-1:0] cnt_nxt;
  logic tail_xfer;
  rr_priority_pick u_pick (.req(req), .ptr(rr_ptr), .pick(pick), .index(pick_idx));
  // state register; reset drops any lock at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      rr_ptr <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      gnt <= gnt_nxt;
      owner <= owner_nxt;
      rr_ptr <= ptr_nxt;
      pkt_count <= cnt_nxt;
    end
  end
  // next state: grant from idle, release after the tail flit crosses
  always_comb begin
    state_nxt = state;
    gnt_nxt = gnt;
    owner_nxt = owner;
    ptr_nxt = rr_ptr;
    cnt_nxt = pkt_count;
    if (state == IDLE && |req) begin
      state_nxt = LOCKED;
      gnt_nxt = pick;
      owner_nxt = pick_idx;
    end else if (tail_xfer) begin
      state_nxt = IDLE;
      gnt_nxt = '0;
      owner_nxt = '0;
      ptr_nxt = next_port(owner);
      cnt_nxt = pkt_count + 1'b1;
    end
  end
  // outputs: a flit moves only while locked, owner has data and downstream has room
  always_comb begin
    xfer = state == LOCKED && owner <= 3'd4 && flit_valid[owner] && out_ready;
    tail_xfer = xfer && flit_tail[owner];
    gnt_valid = |gnt;
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed plan items plus random traffic against a packet-level model
module tb_output_port_arbiter;
  logic clk = 0, rst = 0, out_ready = 0;
  logic [4:0] req = 0, flit_valid = 0, flit_tail = 0, gnt;
  logic gnt_valid, xfer;
  logic [2:0] owner;
  logic [15:0] pkt_count, cnt_save;
  int errors = 0, checks = 0;
  bit m_lock;
  int m_own, m_ptr, m_cnt;
  int seq[$];
  output_port_arbiter #(.NUM_IN(5), .PORT_ID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_valid(flit_valid), .flit_tail(flit_tail),
    .out_ready(out_ready), .gnt(gnt), .gnt_valid(gnt_valid), .owner(owner), .xfer(xfer),
    .pkt_count(pkt_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_lock = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
  endtask
  task automatic step(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t, input logic rdy);
    bit mx;
    req = r; flit_valid = v; flit_tail = t; out_ready = rdy;
    #1;
    mx = m_lock && v[m_own] && rdy;
    chk("xfer", xfer, mx);
    chk("gnt", gnt, m_lock ? 32'd1 << m_own : 32'd0);
    chk("gnt_valid", gnt_valid, m_lock);
    chk("owner", owner, m_lock ? m_own : 0);
    chk("pkt_count", pkt_count, m_cnt % 65536);
    if (m_lock) begin
      if (mx && t[m_own]) begin
        m_lock = 0; m_ptr = (m_own + 1) % 5; m_own = 0; m_cnt++;
      end
    end else if (r != 0) begin
      for (int k = 0; k < 5; k++)
        if (r[(m_ptr + k) % 5]) begin
          m_own = (m_ptr + k) % 5; m_lock = 1; break;
        end
    end
    @(negedge clk);
  endtask
  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_cnt", pkt_count, 0);
    rst = 1;
    step(5'b00010, 0, 0, 1);
    chk("single_gnt", gnt, 5'b00010);
    chk("single_owner", owner, 1);
    step(5'b00010, 5'b00010, 5'b00010, 1);
    step(0, 0, 0, 1);
    chk("single_cnt", pkt_count, 1);
    step(5'b00100, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lock_gnt", gnt, 5'b00100);
      step(5'b01101, 5'b00100, i == 3 ? 5'b00100 : 5'b0, 1);
    end
    step(5'b01101, 0, 0, 1);
    chk("lock_next", owner, 3);
    step(0, 5'b01000, 0, 1);
    cnt_save = pkt_count;
    repeat (10) step(0, 5'b01000, 5'b01000, 0);
    chk("bp_gnt", gnt, 5'b01000);
    chk("bp_cnt", pkt_count, cnt_save);
    step(0, 5'b01000, 5'b01000, 1);
    chk("bp_done", pkt_count, cnt_save + 16'd1);
    step(5'b00100, 0, 0, 1);
    chk("pre_rst_gnt", gnt, 5'b00100);
    #2 rst = 0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_owner", owner, 0);
    chk("async_cnt", pkt_count, 0);
    chk("async_valid", gnt_valid, 0);
    m_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      step(5'b11111, 5'b11111, 5'b11111, 1);
      if (gnt_valid) seq.push_back(int'(owner));
    end
    chk("fair_len", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("fair_seq", seq[i], i % 5);
    step(0, 0, 0, 1);
    chk("fair_cnt", pkt_count, 6);
    step(5'b10000, 0, 0, 1);
    chk("wrap_owner", owner, 4);
    step(0, 5'b10000, 0, 1);
    step(0, 5'b10000, 0, 0);
    chk("drop_gnt", gnt, 5'b10000);
    step(5'b10001, 5'b10000, 5'b10000, 1);
    step(5'b10001, 0, 0, 1);
    chk("wrap_next", owner, 0);
    for (int i = 0; i < 400; i++)
      step(5'($urandom), 5'($urandom), 5'($urandom) & 5'($urandom), $urandom_range(3) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
